// File: rtl/mdio_master.sv
// Clause-22 MDIO/MDC management master: serialises register read/write commands onto MDC/MDIO.
// Define MDIO_POLL_EN to add the periodic BMSR poller that drives link_up/link_status.
module mdio_master #(
    parameter int unsigned CLK_DIV     = 50,
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter int unsigned POLL_PERIOD = 125000
) (
    input  logic        clk125MHz,
    input  logic        rstb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        eth_mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        link_up,
    output logic [15:0] link_status
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

    localparam logic [7:0] DIV_TERM = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  bit_q;
    logic [5:0]  bit_nx;
    logic [63:0] tx_q;
    logic [15:0] rx_q;
    logic        rd_q;
    logic        poll_q;
    logic        err_q;
    logic        mdc_q;
    logic        mdio_o_q;
    logic        mdio_oe_q;
    logic        ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [15:0] rsp_rdata_q;
    logic        link_up_q;
    logic [15:0] link_status_q;
    logic        poll_pend_q;
    logic        poll_term;
    logic        poll_due;
    logic        poll_req;

    assign bit_nx   = bit_q + 6'd1;
    assign poll_req = poll_due | poll_pend_q;

    // Read frames carry all-ones in TA/DATA so the idle level is presented while released.
    function automatic logic [63:0] build_frame(input logic wr, input logic [4:0] ra,
                                                input logic [15:0] wd);
        return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR, ra,
                (wr ? 2'b10 : 2'b11), (wr ? wd : 16'hFFFF)};
    endfunction

`ifdef MDIO_POLL_EN
    localparam int unsigned    PW        = $clog2(POLL_PERIOD);
    localparam logic [PW-1:0]  POLL_TERM = PW'(POLL_PERIOD - 1);

    logic [PW-1:0] ptmr_q;
    logic          pdue_q;

    always_ff @(posedge clk125MHz or posedge rstb) begin
        if (rstb) begin
            ptmr_q <= '0;
            pdue_q <= 1'b0;
        end else begin
            pdue_q <= (ptmr_q == POLL_TERM);
            ptmr_q <= (ptmr_q == POLL_TERM) ? '0 : ptmr_q + PW'(1);
        end
    end

    // poll_term lets cmd_ready drop one cycle early so a poll always wins the tie.
    assign poll_term = (ptmr_q == POLL_TERM);
    assign poll_due  = pdue_q;
`else
    assign poll_term = 1'b0;
    assign poll_due  = 1'b0;
`endif

    always_ff @(posedge clk125MHz or posedge rstb) begin
        if (rstb) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            tx_q          <= '1;
            rx_q          <= '0;
            rd_q          <= 1'b0;
            poll_q        <= 1'b0;
            err_q         <= 1'b0;
            mdc_q         <= 1'b0;
            mdio_o_q      <= 1'b1;
            mdio_oe_q     <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            link_up_q     <= 1'b0;
            link_status_q <= '0;
            poll_pend_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (poll_due) poll_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (poll_req || (cmd_valid && ready_q)) begin
                        state_q     <= S_PRE;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        div_q       <= '0;
                        bit_q       <= '0;
                        mdc_q       <= 1'b0;
                        mdio_o_q    <= 1'b1;
                        mdio_oe_q   <= 1'b1;
                        err_q       <= 1'b0;
                        rx_q        <= '0;
                        poll_q      <= poll_req;
                        rd_q        <= poll_req | ~cmd_write;
                        tx_q        <= poll_req ? build_frame(1'b0, 5'd1, 16'h0000)
                                                : build_frame(cmd_write, cmd_reg, cmd_wdata);
                        if (poll_req) poll_pend_q <= 1'b0;
                    end else begin
                        ready_q <= ~poll_term;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= ~(poll_req | poll_term);
                end
                default: begin
                    if (div_q == DIV_TERM) begin
                        div_q <= '0;
                        mdc_q <= ~mdc_q;
                        if (!mdc_q) begin
                            if (rd_q && bit_q == 6'd47) err_q <= mdio_i;
                            if (rd_q && bit_q >= 6'd48) rx_q <= {rx_q[14:0], mdio_i};
                        end else if (bit_q == 6'd63) begin
                            state_q   <= S_DONE;
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                            if (poll_q) begin
                                if (!err_q) begin
                                    link_status_q <= rx_q;
                                    link_up_q     <= rx_q[2];
                                end
                            end else begin
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= rd_q ? rx_q : 16'h0000;
                                rsp_err_q   <= rd_q & err_q;
                            end
                        end else begin
                            bit_q    <= bit_nx;
                            mdio_o_q <= tx_q[~bit_nx];
                            if (rd_q && bit_q == 6'd45) mdio_oe_q <= 1'b0;
                            if (bit_q == 6'd31) state_q <= S_HDR;
                            else if (bit_q == 6'd45) state_q <= S_TA;
                            else if (bit_q == 6'd47) state_q <= S_DATA;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign eth_mdc     = mdc_q;
    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;
    assign link_up     = link_up_q;
    assign link_status = link_status_q;
endmodule

// File: tb/tb_mdio_master.sv
// Directed + randomized bench for mdio_master with a behavioural clause-22 PHY on the wire.
// Build with MDIO_POLL_EN defined to exercise the status poller instead of the command tests.
module tb_mdio_master;
    localparam int          CLK_DIV   = 4;
    localparam logic [4:0]  PHY       = 5'd1;
    localparam int          FRAME_CYC = 64 * 2 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_reg = 5'd0;
    logic [15:0] cmd_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        eth_mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;
    logic        link_up;
    logic [15:0] link_status;

    int n_cmp = 0;
    int n_bad = 0;

    always #4 clk = ~clk;

    mdio_master #(.CLK_DIV(CLK_DIV), .PHY_ADDR(PHY), .POLL_PERIOD(1000)) dut (
        .clk125MHz(clk), .rstb(rstb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .eth_mdc(eth_mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i),
        .link_up(link_up), .link_status(link_status)
    );

    function automatic logic [15:0] init_val(input logic [4:0] r);
        return (r == 5'd1) ? 16'h796D : ({r, r, r, 1'b0} ^ 16'hA55A);
    endfunction

    // ---------------- behavioural PHY (captures the line on MDC rise) ----------------
    logic        phy_present = 1'b1;
    logic        drv_en = 1'b0;
    logic        drv_bit = 1'b1;
    logic [15:0] rd_word = 16'h0;
    logic [63:0] cap = 64'h0;
    logic [63:0] last_frame = 64'h0;
    logic [63:0] frames[$];
    logic [15:0] phy_mem [32];
    logic [31:0] phy_written = 32'h0;
    int          k = 0;
    int          frame_cnt = 0;
    int          oe_bad = 0;
    logic        line;

    assign mdio_i = drv_en ? drv_bit : 1'b1;
    assign line   = mdio_oe ? mdio_o : mdio_i;

    always @(posedge eth_mdc or negedge busy) begin
        if (!busy) begin
            k = 0;
            drv_en = 1'b0;
        end else begin
            cap[63-k] = line;
            if (k >= 46 && cap[29:28] == 2'b10 && mdio_oe) oe_bad++;
            if (k == 46 && phy_present && cap[29:28] == 2'b10 && cap[27:23] == PHY) begin
                rd_word = phy_written[cap[22:18]] ? phy_mem[cap[22:18]] : init_val(cap[22:18]);
                drv_en  = 1'b1;
                drv_bit = 1'b0;
            end else if (k >= 47 && k <= 62 && drv_en) begin
                drv_bit = rd_word[62-k];
            end
            if (k == 63) begin
                drv_en = 1'b0;
                last_frame = cap;
                frames.push_back(cap);
                frame_cnt++;
                if (phy_present && cap[29:28] == 2'b01 && cap[27:23] == PHY) begin
                    phy_mem[cap[22:18]] = cap[15:0];
                    phy_written[cap[22:18]] = 1'b1;
                end
            end
            k++;
        end
    end

    int rsp_cnt = 0;
    int ready_bad = 0;
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (busy && cmd_ready) ready_bad++;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [32];

    function automatic logic [63:0] exp_frame(input logic wr, input logic [4:0] ra,
                                              input logic [15:0] wd, input logic present,
                                              input logic [15:0] rv);
        if (wr) return {32'hFFFF_FFFF, 4'b0101, PHY, ra, 2'b10, wd};
        return {32'hFFFF_FFFF, 4'b0110, PHY, ra, (present ? 2'b10 : 2'b11),
                (present ? rv : 16'hFFFF)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_write = 1'($urandom_range(0, 1));
        cmd_reg   = 5'($urandom_range(0, 31));
        cmd_wdata = 16'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the DONE cycle.
    task automatic do_cmd(input logic wr, input logic [4:0] ra, input logic [15:0] wd,
                          input bit hold, input bit ready_after);
        int n;
        logic [63:0] ef;
        logic [15:0] er;
        logic        ee;
        ef = exp_frame(wr, ra, wd, phy_present, ref_mem[ra]);
        if (wr) begin
            er = 16'h0; ee = 1'b0;
            if (phy_present) ref_mem[ra] = wd;
        end else if (phy_present) begin
            er = ref_mem[ra]; ee = 1'b0;
        end else begin
            er = 16'hFFFF; ee = 1'b1;
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_reg = ra; cmd_wdata = wd;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("accept_wait", n < 2000, 1'b1);
        @(negedge clk);
        if (hold) scramble_cmd(); else cmd_valid = 1'b0;
        check("start_pins", {busy, cmd_ready, mdio_oe, mdio_o}, 4'b1011);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (hold) scramble_cmd();
        end
        check("latency", n, FRAME_CYC);
        check("frame", last_frame, ef);
        check("rdata", rsp_rdata, er);
        check("err", rsp_err, ee);
        check("done_pins", {mdio_oe, mdio_o}, 2'b01);
        @(negedge clk);
        check("pulse_width", rsp_valid, 1'b0);
        if (ready_after) check("ready_after_done", cmd_ready, 1'b1);
        check("rdata_stable", rsp_rdata, er);
        $display("txn %s reg=%0d wdata=%h -> rdata=%h err=%0b lat=%0d",
                 wr ? "WR" : "RD", ra, wd, rsp_rdata, rsp_err, n);
    endtask

    initial begin
        int rc0;
        int fc0;
        int n;
        logic        wr;
        logic [4:0]  ra;
        logic [15:0] wd;

        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(5'(i));

        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
        check("rst_pins", {eth_mdc, mdio_o, mdio_oe}, 3'b010);
        check("rst_link", {link_up, link_status}, 17'h0);

`ifdef MDIO_POLL_EN
        // Wait for the cycle where the poll fires: idle but not ready.
        n = 0;
        while (!(cmd_ready === 1'b0 && busy === 1'b0) && n < 1500) begin @(negedge clk); n++; end
        check("poll_due_seen", n < 1500, 1'b1);
        rc0 = rsp_cnt;
        fc0 = frame_cnt;
        do_cmd(1'b0, 5'd3, 16'h0, 1'b0, 1'b0);
        check("poll_frames", frame_cnt - fc0, 2);
        if (frames.size() > fc0)
            check("poll_first", frames[fc0], exp_frame(1'b0, 5'd1, 16'h0, 1'b1, 16'h796D));
        check("link_up", link_up, 1'b1);
        check("link_status", link_status, 16'h796D);
        check("rsp_only_cmd", rsp_cnt - rc0, 1);
`else
        // Test-plan write; also check against the literal bit pattern.
        do_cmd(1'b1, 5'd0, 16'h1140, 1'b0, 1'b1);
        check("wr_literal", last_frame, 64'hFFFF_FFFF_5082_1140);
        do_cmd(1'b0, 5'd1, 16'h0, 1'b0, 1'b1);
        phy_present = 1'b0;
        do_cmd(1'b0, 5'd2, 16'h0, 1'b0, 1'b1);
        phy_present = 1'b1;
        // Held cmd_valid with a changing command; the next one goes right after DONE.
        do_cmd(1'b1, 5'd5, 16'hBEEF, 1'b1, 1'b1);
        do_cmd(1'b0, 5'd5, 16'h0, 1'b0, 1'b1);
        for (int t = 0; t < 10; t++) begin
            wr = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 7));
            wd = 16'($urandom);
            do_cmd(wr, ra, wd, 1'b0, 1'b1);
        end

        // Abort mid-frame at bit 40 while MDC is high.
        rc0 = rsp_cnt;
        fc0 = frame_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 5'd6; cmd_wdata = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40 * 2 * CLK_DIV + CLK_DIV + 1) @(negedge clk);
        check("pre_abort", {busy, eth_mdc, mdio_oe}, 3'b111);
        rstb = 1'b1;
        #1;
        check("abort_pins", {busy, eth_mdc, mdio_oe, cmd_ready}, 4'b0001);
        $display("abort at bit 40: busy=%0b mdc=%0b oe=%0b", busy, eth_mdc, mdio_oe);
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        repeat (FRAME_CYC + 50) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rc0, 0);
        check("abort_no_frame", frame_cnt - fc0, 0);
        do_cmd(1'b0, 5'd1, 16'h0, 1'b0, 1'b1);
        check("link_const", {link_up, link_status}, 17'h0);
`endif
        check("read_oe_released", oe_bad, 0);
        check("ready_while_busy", ready_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
# mdio_master

Ethernet PHY management (MDIO/MDC) controller on the `clk125MHz` domain. It accepts register read/write commands over a valid/ready handshake and serialises them as IEEE 802.3 clause-22 frames on `eth_mdc`/`eth_mdio`. The optional poller reads the PHY status register periodically and reports link state. It sits beside `rgmii_rx`/`ethernet_tx` in the top level and replaces the static `eth_mdc` tie-off.

## Interface

Parameters:
- `CLK_DIV`, default 50: half-period of MDC in `clk125MHz` cycles. Default MDC is 1.25 MHz. Legal range is 2..255.
- `PHY_ADDR`, default 5'd1: PHY address field used in every frame.
- `POLL_PERIOD`, default 125000: cycles between status polls (1 ms). Used only with the poll feature.

Ports:
- `clk125MHz` in 1: the only clock.
- `rstb` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 selects write, 0 selects read.
- `cmd_reg` in 5: PHY register address.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle pulse when a command frame completes.
- `rsp_rdata` out 16: read data. Reads 0 for writes.
- `rsp_err` out 1: read got no turnaround response. Valid with `rsp_valid`.
- `busy` out 1: a frame is in progress.
- `eth_mdc` out 1: management clock.
- `mdio_o` out 1: MDIO output bit.
- `mdio_oe` out 1: MDIO output enable. The top level builds the tristate.
- `mdio_i` in 1: MDIO input.
- `link_up` out 1: BMSR bit 2 from the last poll.
- `link_status` out 16: last polled BMSR value.

## Operation

- MDC is generated by a counter 0..`CLK_DIV`-1.
  - At the terminal count, MDC toggles.
  - On the toggle low→high, a "rise tick" occurs.
  - On the toggle high→low, a "fall tick" occurs.
  - MDC runs only while busy. In IDLE it is held at 0.
- A frame is 64 bits, MSB first:
  - 32 preamble ones
  - ST = 01
  - OP = 01 for write, 10 for read
  - PHYAD, 5 bits
  - REGAD, 5 bits
  - TA, 2 bits
  - DATA, 16 bits
- Output timing:
  - The controller changes `mdio_o` only on fall ticks, or at frame start.
  - Read data is sampled on rise ticks.
- States and transitions:
  - IDLE → PRE on accept. The command is latched. `busy` goes to 1 and `cmd_ready` goes to 0.
  - PRE lasts 32 bits, then moves to HDR.
  - HDR lasts 14 bits, then moves to TA.
  - TA lasts 2 bits, then moves to DATA.
  - DATA lasts 16 bits, then moves to DONE.
  - DONE lasts one clock, then returns to IDLE.
- Turnaround (TA) behaviour:
  - Write: drive 1 then 0.
  - Read: `mdio_oe` = 0 for both TA bits and all of DATA.
  - Read: `mdio_i` is sampled at the second TA rise tick. If it is 1, `rsp_err` = 1.
- Read data:
  - Shifted in MSB first on the 16 DATA rise ticks.
  - On error, `rsp_rdata` still shows the sampled bits. A floating line gives 16'hFFFF.
- DONE:
  - `rsp_valid` = 1 for exactly one cycle for command frames.
  - After DONE, `mdio_oe` = 0 and `mdio_o` = 1.
- `cmd_ready` = 1 only in IDLE with no poll pending. Inputs are ignored while it is 0.
- Async reset: all state returns to IDLE immediately, mid-frame included. No `rsp_valid` is issued for an aborted frame.
- Reset values:
  - `cmd_ready`=1, `busy`=0
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
  - `eth_mdc`=0, `mdio_o`=1, `mdio_oe`=0
  - `link_up`=0, `link_status`=0

## Timing

- Accept to first preamble bit on the pins: 1 cycle.
- One frame lasts 64×2×`CLK_DIV` cycles plus 1 cycle of DONE. At the default this is 6401 cycles.
- Back-to-back commands: the next accept is possible in the cycle after DONE. At least 1 idle clock separates frames.
- `rsp_rdata` and `rsp_err` are stable from `rsp_valid` until the next `rsp_valid`.
- All outputs are registered.

## Configuration

- `MDIO_POLL_EN` defined:
  - A free-running counter sets `poll_due` every `POLL_PERIOD` cycles.
  - In IDLE, `poll_due` has priority over `cmd_valid`. On a simultaneous event, the poll runs first and `cmd_ready` = 0 in that cycle.
  - A poll is a read of register 1.
  - On completion, `link_status` ← rdata and `link_up` ← rdata[2], unless `rsp_err` would be set; on error both keep their old value.
  - A poll does not pulse `rsp_valid` and does not change `rsp_rdata`/`rsp_err`.
  - If a poll expires while busy, it stays pending until IDLE. Pending polls do not accumulate.
- `MDIO_POLL_EN` undefined: no timer and no poll. `link_up` and `link_status` are constant 0.

## Test plan

- Write reg 0 with 16'h1140, `CLK_DIV`=4 → the 64 bits captured on MDC rise are: 32×1, 0101, 00001, 00000, 10, 0001000101000000. Then `rsp_valid` pulses with `rsp_rdata`=0 and `rsp_err`=0.
- Read reg 1 against a PHY model returning 16'h796D → `mdio_oe`=0 from TA onward, `rsp_rdata`=16'h796D, `rsp_err`=0.
- Read with MDIO pulled up and no PHY → `rsp_err`=1, `rsp_rdata`=16'hFFFF.
- `cmd_valid` held during a frame with changing `cmd_reg` → `cmd_ready`=0 and the frame is unaffected. The second command is accepted the cycle after DONE.
- Assert `rstb` at bit 40 → the same cycle gives `eth_mdc`=0, `mdio_oe`=0 and `busy`=0. No `rsp_valid`.
- With `MDIO_POLL_EN`, `POLL_PERIOD`=1000, poll expiry coincident with `cmd_valid`, and the PHY returning BMSR 16'h796D → the poll frame goes first and `link_up`=1. The command follows, and `rsp_valid` fires only for the command.
